// File: rtl/sample_player.sv
// Sample RAM playback engine: the host fills a 4096-word RAM, and each accepted tick
// reads the next word at a step/range-wrapped pointer, presenting it 2 cycles later.
module sample_player #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int DEPTH_LOG2   = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_enable,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [OUTPUT_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]   step,
  input  logic [DEPTH_LOG2-1:0]   range,
  input  logic                    run,
  input  logic                    sample_tick,
  output logic [OUTPUT_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic [DEPTH_LOG2-1:0]   rd_ptr
);

  localparam int AW = DEPTH_LOG2;

  logic [OUTPUT_WIDTH-1:0] r_mem [2**AW];
  logic [AW-1:0]           r_rd_ptr;
  logic                    r_run_q;
  logic [OUTPUT_WIDTH-1:0] r_data_p1;
  logic                    r_vld_p1;
  logic [OUTPUT_WIDTH-1:0] r_sample_p2;
  logic                    r_vld_p2;

  logic          w_tick;
  logic          w_run_fall;
  logic [AW-1:0] w_ea;
  logic [AW-1:0] w_next;

  // Wrap in one extra bit of headroom so step > range lands on 0 instead of aliasing.
  function automatic logic [AW-1:0] wrap_ptr(input logic [AW-1:0] ea,
                                             input logic [AW-1:0] st,
                                             input logic [AW-1:0] rg);
    logic [AW:0] sum;
    logic [AW:0] lim;
    logic [AW:0] wrapped;
    sum     = {1'b0, ea} + {1'b0, st};
    lim     = {1'b0, rg} + (AW+1)'(1);
    wrapped = sum - lim;
    if (sum <= {1'b0, rg})
      return sum[AW-1:0];
    else if (wrapped <= {1'b0, rg})
      return wrapped[AW-1:0];
    else
      return '0;
  endfunction

  assign w_tick     = run & sample_tick;
  assign w_run_fall = r_run_q & ~run;
  assign w_ea       = (r_rd_ptr > range) ? '0 : r_rd_ptr;
  assign w_next     = wrap_ptr(w_ea, step, range);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_run_q  <= 1'b0;
    end else begin
      r_run_q <= run;
      if (w_run_fall)
        r_rd_ptr <= '0;
      else if (w_tick)
        r_rd_ptr <= w_next;
    end
  end

  // Stage p1: RAM read registered (read-before-write on a same-address collision)
  always_ff @(posedge clk) begin
    if (wr_enable)
      r_mem[wr_addr] <= wr_data;
    if (w_tick)
      r_data_p1 <= r_mem[w_ea];
  end

  // Stage p2: output register, holds its value while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_sample_p2 <= '0;
    end else begin
      r_vld_p1 <= w_tick;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1)
        r_sample_p2 <= r_data_p1;
    end
  end

  assign sample_out   = r_sample_p2;
  assign sample_valid = r_vld_p2;
  assign rd_ptr       = r_rd_ptr;

endmodule

// File: tb/tb_sample_player.sv
// Scoreboard bench for sample_player: a driver feeds directed and random traffic into
// a behavioural model that queues expected samples; a monitor checks every cycle.
module tb_sample_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_enable;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [11:0] cfg_step;
  logic [11:0] cfg_range;
  logic        run_i;
  logic        sample_tick;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [11:0] rd_ptr;

  sample_player #(.OUTPUT_WIDTH(16), .DEPTH_LOG2(12)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .step(cfg_step), .range(cfg_range), .run(run_i),
    .sample_tick(sample_tick), .sample_out(sample_out),
    .sample_valid(sample_valid), .rd_ptr(rd_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          due;
    logic [15:0] d;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mmem [4096];
  int          mptr;
  logic        run_prev;
  logic [15:0] last_out;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // One cycle of stimulus; the model applies the playback rules with plain integers.
  task automatic step_cyc(input logic tk, input logic we, input logic [11:0] wa,
                          input logic [15:0] wd);
    int ea, s, rg, nx;
    exp_t e;
    sample_tick = tk;
    wr_enable   = we;
    wr_addr     = wa;
    wr_data     = wd;
    rg = int'(cfg_range);
    if (run_i && tk) begin
      ea = (mptr > rg) ? 0 : mptr;
      e.due = cyc + 2;
      e.d   = mmem[ea];
      q.push_back(e);
      s = ea + int'(cfg_step);
      if (s <= rg) nx = s;
      else if (s - (rg + 1) <= rg) nx = s - (rg + 1);
      else nx = 0;
      mptr = nx;
    end else if (run_prev && !run_i) begin
      mptr = 0;
    end
    if (we) mmem[wa] = wd;
    run_prev = run_i;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cyc(1'b0, 1'b0, 12'd0, 16'd0);
  endtask

  task automatic tick_gap(input int n);
    step_cyc(1'b1, 1'b0, 12'd0, 16'd0);
    idle(n - 1);
  endtask

  task automatic restart();
    run_i = 1'b0;
    idle(1);
    run_i = 1'b1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    run_i       = 1'b0;
    sample_tick = 1'b0;
    wr_enable   = 1'b0;
    q.delete();
    mptr     = 0;
    run_prev = 1'b0;
    last_out = 16'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        checks++;
        if (sample_valid !== 1'b0 || sample_out !== 16'd0 || rd_ptr !== 12'd0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d valid=%b out=%h ptr=%0d required 0/0000/0",
                   cyc, sample_valid, sample_out, rd_ptr);
        end
      end else begin
        while (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_valid cyc=%0d no pulse, required %h at cyc %0d", cyc, e.d, e.due);
        end
        checks++;
        if (sample_valid) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid cyc=%0d out=%h required no pulse", cyc, sample_out);
            last_out = sample_out;
          end else begin
            e = q.pop_front();
            if (e.due != cyc || sample_out !== e.d) begin
              errors++;
              $display("FAIL sample cyc=%0d out=%h required %h at cyc %0d", cyc, sample_out, e.d, e.due);
            end
            last_out = e.d;
          end
        end else if (sample_out !== last_out) begin
          errors++;
          $display("FAIL hold cyc=%0d out=%h required %h", cyc, sample_out, last_out);
        end
        checks++;
        if (int'(rd_ptr) != mptr) begin
          errors++;
          $display("FAIL rd_ptr cyc=%0d ptr=%0d required %0d", cyc, rd_ptr, mptr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; run_i = 1'b0; sample_tick = 1'b0; wr_enable = 1'b0;
    wr_addr = '0; wr_data = '0; cfg_step = 12'd1; cfg_range = 12'd7;
    mptr = 0; run_prev = 1'b0; last_out = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload the whole RAM so every address has known contents.
    for (int a = 0; a < 4096; a++) step_cyc(1'b0, 1'b1, 12'(a), 16'($urandom));
    for (int a = 0; a < 8; a++) step_cyc(1'b0, 1'b1, 12'(a), 16'h1000 + 16'(a));

    // Sequential playback with a tick every 4 cycles, wrapping 7 -> 0.
    cfg_step = 12'd1; cfg_range = 12'd7; run_i = 1'b1;
    for (int i = 0; i < 9; i++) tick_gap(4);

    // Back-to-back ticks, step 3.
    cfg_step = 12'd3;
    restart();
    for (int i = 0; i < 6; i++) step_cyc(1'b1, 1'b0, 12'd0, 16'd0);
    idle(3);

    // step larger than range.
    cfg_step = 12'd10;
    restart();
    for (int i = 0; i < 5; i++) tick_gap(2);

    // Range lowered below the current pointer.
    cfg_step = 12'd1;
    restart();
    for (int i = 0; i < 5; i++) tick_gap(2);
    tick_gap(2);
    cfg_range = 12'd3;
    tick_gap(3);

    // Same-cycle read and write of address 4.
    cfg_range = 12'd7;
    restart();
    for (int i = 0; i < 4; i++) tick_gap(2);
    step_cyc(1'b1, 1'b1, 12'd4, 16'hBEEF);
    idle(2);
    for (int i = 0; i < 8; i++) tick_gap(2);

    // Reset one cycle after a tick kills the in-flight read.
    tick_gap(1);
    do_reset();
    idle(4);

    // Drop run mid-play with a read in flight, then resume from address 0.
    run_i = 1'b1;
    for (int i = 0; i < 3; i++) tick_gap(2);
    step_cyc(1'b1, 1'b0, 12'd0, 16'd0);
    run_i = 1'b0;
    step_cyc(1'b1, 1'b0, 12'd0, 16'd0);
    idle(3);
    run_i = 1'b1;
    for (int i = 0; i < 3; i++) tick_gap(2);

    // Full-range wrap 4095 -> 0, and range 0 / step 0 corners.
    cfg_range = 12'd4095; cfg_step = 12'd4094;
    restart();
    tick_gap(2);
    cfg_step = 12'd1;
    for (int i = 0; i < 3; i++) tick_gap(2);
    cfg_range = 12'd0; cfg_step = 12'd5;
    for (int i = 0; i < 3; i++) tick_gap(1);
    cfg_range = 12'd9; cfg_step = 12'd0;
    for (int i = 0; i < 3; i++) tick_gap(1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_step  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 12));
        cfg_range = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) run_i = ~run_i;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step_cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom),
                 16'($urandom));
      end
    end

    run_i = 1'b0;
    idle(6);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
